seg7_capture: RTL and testbench

//  Decodes multiplexed 7-segment display lines (segments plus digit strobes) back into per-digit hex nibbles.

---
 rtl/seg7_capture_if.sv | 30 +++
 rtl/seg7_capture.sv | 191 +++++++++++++++++++
 tb/tb_seg7_capture.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seg7_capture_if.sv
// seg7_capture_if: display-bus bundle for the 7-segment readback monitor.
//   seg_in      : segments {g,f,e,d,c,b,a}, seg_in[0] = g, active-high
//   an_in       : one-hot digit strobe, bit k = digit k
//   clr         : synchronous clear of captured state
//   digits_out  : captured nibbles, digit k at [4k+3:4k]
//   blank_out   : digit k last captured as all segments off
//   err_out     : sticky illegal-pattern / multi-hot-strobe flag
//   frame_valid : one-cycle pulse once every digit has been captured
// master drives the display lines, slave is the capture monitor.
interface seg7_capture_if #(
  parameter int unsigned N_DIGITS = 4
);
  logic [0:6]            seg_in;
  logic [N_DIGITS-1:0]   an_in;
  logic                  clr;
  logic [4*N_DIGITS-1:0] digits_out;
  logic [N_DIGITS-1:0]   blank_out;
  logic                  err_out;
  logic                  frame_valid;

  modport master (
    output seg_in, an_in, clr,
    input  digits_out, blank_out, err_out, frame_valid
  );

  modport slave (
    input  seg_in, an_in, clr,
    output digits_out, blank_out, err_out, frame_valid
  );
endinterface

// File: rtl/seg7_capture.sv
// seg7_capture: decodes multiplexed 7-segment lines back into per-digit hex
// nibbles. A sample {an,seg} is captured once it has been seen on
// STABLE_CYCLES consecutive edges; only one capture is taken per dwell.
// Ports:
//   clk     : system clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : seg7_capture_if.slave (seg_in, an_in, clr in; digits_out,
//             blank_out, err_out, frame_valid out, all registered)
// Build option:
//   SEGCAP_SYNC_EN : adds a 2-flop synchroniser on seg_in/an_in ahead of
//                    sampling (+2 cycles latency) for asynchronous sources.
module seg7_capture #(
  parameter int unsigned N_DIGITS      = 4,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  seg7_capture_if.slave   bus
);

  localparam int unsigned SEG_W = 7;
  localparam int unsigned S_W   = N_DIGITS + SEG_W;
  localparam int unsigned DIG_W = 4 * N_DIGITS;
  localparam int unsigned CNT_W = $clog2(STABLE_CYCLES);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ARM = CNT_W'(STABLE_CYCLES - 2);

  localparam logic [0:0] ST_TRACK    = 1'b0;
  localparam logic [0:0] ST_CAPTURED = 1'b1;

  // Decode {g..a} into {legal, nibble}; all-off is handled separately.
  function automatic logic [4:0] decode_seg(input logic [SEG_W-1:0] p);
    logic [4:0] r;
    r = 5'h00;
    case (p)
      7'b0111111: r = {1'b1, 4'h0};
      7'b0000110: r = {1'b1, 4'h1};
      7'b1011011: r = {1'b1, 4'h2};
      7'b1001111: r = {1'b1, 4'h3};
      7'b1100110: r = {1'b1, 4'h4};
      7'b1101101: r = {1'b1, 4'h5};
      7'b1111101: r = {1'b1, 4'h6};
      7'b0000111: r = {1'b1, 4'h7};
      7'b1111111: r = {1'b1, 4'h8};
      7'b1101111: r = {1'b1, 4'h9};
      7'b1110111: r = {1'b1, 4'hA};
      7'b1111100: r = {1'b1, 4'hB};
      7'b0111001: r = {1'b1, 4'hC};
      7'b1011110: r = {1'b1, 4'hD};
      7'b1111001: r = {1'b1, 4'hE};
      7'b1110001: r = {1'b1, 4'hF};
      default:    r = 5'h00;
    endcase
    return r;
  endfunction

  logic [S_W-1:0] s;

`ifdef SEGCAP_SYNC_EN
  logic [S_W-1:0] sync_q1;
  logic [S_W-1:0] sync_q2;

  // Two-flop synchroniser for pin-level display lines.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= {bus.an_in, bus.seg_in};
      sync_q2 <= sync_q1;
    end
  end

  assign s = sync_q2;
`else
  assign s = {bus.an_in, bus.seg_in};
`endif

  logic [0:0]          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [S_W-1:0]      s_prev_q;
  logic [DIG_W-1:0]    digits_q, digits_d;
  logic [N_DIGITS-1:0] blank_q, blank_d;
  logic                err_q, err_d;
  logic [N_DIGITS-1:0] seen_q, seen_d;
  logic                fv_q, fv_d;

  logic                match;
  logic                capture;
  logic [N_DIGITS-1:0] an_v;
  logic [SEG_W-1:0]    seg_v;
  logic [4:0]          dec;

  // State register and captured outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_TRACK;
      cnt_q    <= '0;
      s_prev_q <= '0;
      digits_q <= '0;
      blank_q  <= '1;
      err_q    <= 1'b0;
      seen_q   <= '0;
      fv_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      s_prev_q <= s;
      digits_q <= digits_d;
      blank_q  <= blank_d;
      err_q    <= err_d;
      seen_q   <= seen_d;
      fv_q     <= fv_d;
    end
  end

  // Stability tracking, capture evaluation and frame bookkeeping.
  always_comb begin
    state_d  = state_q;
    cnt_d    = '0;
    digits_d = digits_q;
    blank_d  = blank_q;
    err_d    = err_q;
    seen_d   = seen_q;
    fv_d     = 1'b0;
    capture  = 1'b0;
    match    = (s == s_prev_q);
    an_v     = s[S_W-1:SEG_W];
    seg_v    = s[SEG_W-1:0];
    dec      = decode_seg(seg_v);

    if (match) begin
      cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
    end

    // Capture fires on the edge that makes the dwell STABLE_CYCLES samples long.
    case (state_q)
      ST_TRACK: begin
        if (match && (cnt_q == CNT_ARM)) begin
          capture = 1'b1;
          state_d = ST_CAPTURED;
        end
      end
      ST_CAPTURED: begin
        if (!match) state_d = ST_TRACK;
      end
      default: state_d = ST_TRACK;
    endcase

    if (capture && (an_v != '0)) begin
      if (!$onehot(an_v)) begin
        err_d = 1'b1;
      end else if (seg_v == '0) begin
        blank_d = blank_q | an_v;
        seen_d  = seen_q | an_v;
      end else if (dec[4]) begin
        for (int k = 0; k < int'(N_DIGITS); k++) begin
          if (an_v[k]) digits_d[4*k +: 4] = dec[3:0];
        end
        blank_d = blank_q & ~an_v;
        seen_d  = seen_q | an_v;
      end else begin
        err_d = 1'b1;
      end

      // Completing the frame pulses and restarts the seen mask on the same edge.
      if (&seen_d) begin
        fv_d   = 1'b1;
        seen_d = '0;
      end
    end

    // Clear wins over a capture in the same cycle.
    if (bus.clr) begin
      state_d  = ST_TRACK;
      cnt_d    = '0;
      digits_d = '0;
      blank_d  = '1;
      err_d    = 1'b0;
      seen_d   = '0;
      fv_d     = 1'b0;
    end
  end

  assign bus.digits_out  = digits_q;
  assign bus.blank_out   = blank_q;
  assign bus.err_out     = err_q;
  assign bus.frame_valid = fv_q;

endmodule

// File: tb/tb_seg7_capture.sv
// tb_seg7_capture: directed + randomized bench for seg7_capture with a
// run-length / lookup-table reference model. Honours SEGCAP_SYNC_EN.
module tb_seg7_capture;

  localparam int unsigned ND = 4;
  localparam int unsigned SC = 4;
`ifdef SEGCAP_SYNC_EN
  localparam int unsigned SYNC = 2;
`else
  localparam int unsigned SYNC = 0;
`endif
  localparam int unsigned LAT = SC + SYNC;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  seg7_capture_if #(.N_DIGITS(ND)) bus ();

  seg7_capture #(.N_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [6:0] seg_tab [16] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
    7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
    7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
    7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
  };

  // Reference model state.
  logic [4*ND-1:0] m_dig;
  logic [ND-1:0]   m_blank;
  logic            m_err;
  logic [ND-1:0]   m_seen;
  logic            m_fv;
  logic [ND+6:0]   prev_s;
  int              run_len;
`ifdef SEGCAP_SYNC_EN
  logic [ND+6:0]   pipe [2];
`endif

  task automatic model_reset();
    m_dig   = '0;
    m_blank = '1;
    m_err   = 1'b0;
    m_seen  = '0;
    m_fv    = 1'b0;
    prev_s  = '0;
    run_len = 1;
`ifdef SEGCAP_SYNC_EN
    pipe[0] = '0;
    pipe[1] = '0;
`endif
  endtask

  task automatic model_capture(input logic [ND+6:0] s);
    logic [ND-1:0] an;
    logic [6:0]    sg;
    int            k;
    int            idx;
    an = s[ND+6:7];
    sg = s[6:0];
    if (an == '0) return;
    if ($countones(an) != 1) begin
      m_err = 1'b1;
      return;
    end
    k = 0;
    for (int i = 0; i < int'(ND); i++) if (an[i]) k = i;
    if (sg == 7'd0) begin
      m_blank[k] = 1'b1;
    end else begin
      idx = -1;
      for (int i = 0; i < 16; i++) if (seg_tab[i] == sg) idx = i;
      if (idx < 0) begin
        m_err = 1'b1;
        return;
      end
      m_dig[4*k +: 4] = 4'(idx);
      m_blank[k]      = 1'b0;
    end
    m_seen[k] = 1'b1;
    if (m_seen == '1) begin
      m_fv   = 1'b1;
      m_seen = '0;
    end
  endtask

  // Drive one cycle of inputs, advance the model, land #1 after the edge.
  task automatic step(input logic [ND-1:0] an, input logic [6:0] sg, input logic c);
    logic [ND+6:0] s;
    bus.an_in  = an;
    bus.seg_in = sg;
    bus.clr    = c;
`ifdef SEGCAP_SYNC_EN
    s       = pipe[1];
    pipe[1] = pipe[0];
    pipe[0] = {an, sg};
`else
    s = {an, sg};
`endif
    m_fv = 1'b0;
    if (c) begin
      m_dig   = '0;
      m_blank = '1;
      m_err   = 1'b0;
      m_seen  = '0;
      run_len = 1;
    end else begin
      if (s == prev_s) run_len++;
      else run_len = 1;
      if (run_len == int'(SC)) model_capture(s);
    end
    prev_s = s;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n    = 1'b0;
    bus.an_in  = '0;
    bus.seg_in = '0;
    bus.clr    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    if (bus.digits_out !== 16'h0000) begin n_err++; $display("FAIL reset_digits got=%h exp=0000", bus.digits_out); end
    n_vec++;
    if (bus.blank_out !== 4'hF) begin n_err++; $display("FAIL reset_blank got=%h exp=F", bus.blank_out); end
    n_vec++;
    if (bus.err_out !== 1'b0) begin n_err++; $display("FAIL reset_err got=%b exp=0", bus.err_out); end
    n_vec++;
    if (bus.frame_valid !== 1'b0) begin n_err++; $display("FAIL reset_fv got=%b exp=0", bus.frame_valid); end
    n_vec++;
    reset_n = 1'b1;
    model_reset();
  endtask

  // Digit 0 shows 5 exactly LAT edges after the pattern appears, once.
  task automatic test_single_capture();
    logic [3:0] exp;
    for (int i = 0; i < 10; i++) begin
      step(4'b0001, 7'b1101101, 1'b0);
      exp = (i >= int'(LAT) - 1) ? 4'h5 : 4'h0;
      if (bus.digits_out[3:0] !== exp) begin n_err++; $display("FAIL single_dig0 i=%0d got=%h exp=%h", i, bus.digits_out[3:0], exp); end
      n_vec++;
      if (bus.frame_valid !== 1'b0) begin n_err++; $display("FAIL single_fv i=%0d got=%b exp=0", i, bus.frame_valid); end
      n_vec++;
    end
    if (bus.blank_out !== 4'hE) begin n_err++; $display("FAIL single_blank got=%h exp=E", bus.blank_out); end
    n_vec++;
  endtask

  // Scan 1,2,3,4 onto digits 0..3; exactly one frame pulse after digit 3.
  task automatic test_frame();
    int pulses;
    logic exp_fv;
    pulses = 0;
    for (int d = 0; d < 4; d++) begin
      for (int i = 0; i < 8; i++) begin
        step(4'(1 << d), seg_tab[d+1], 1'b0);
        exp_fv = (d == 3) && (i == int'(LAT) - 1);
        if (bus.frame_valid === 1'b1) pulses++;
        if (bus.frame_valid !== exp_fv) begin n_err++; $display("FAIL frame_fv d=%0d i=%0d got=%b exp=%b", d, i, bus.frame_valid, exp_fv); end
        n_vec++;
      end
    end
    if (pulses != 1) begin n_err++; $display("FAIL frame_pulses got=%0d exp=1", pulses); end
    n_vec++;
    if (bus.digits_out !== 16'h4321) begin n_err++; $display("FAIL frame_digits got=%h exp=4321", bus.digits_out); end
    n_vec++;
    if (bus.blank_out !== 4'h0) begin n_err++; $display("FAIL frame_blank got=%h exp=0", bus.blank_out); end
    n_vec++;
  endtask

  // A dwell one sample short of STABLE_CYCLES must not capture.
  task automatic test_short_dwell();
    for (int i = 0; i < int'(SC) - 1; i++) step(4'b0010, 7'b0000110, 1'b0);
    for (int i = 0; i < int'(LAT) + 2; i++) step(4'b0000, 7'b0000000, 1'b0);
    if (bus.digits_out !== 16'h4321) begin n_err++; $display("FAIL short_digits got=%h exp=4321", bus.digits_out); end
    n_vec++;
    if (bus.err_out !== 1'b0) begin n_err++; $display("FAIL short_err got=%b exp=0", bus.err_out); end
    n_vec++;
  endtask

  // Illegal pattern sets sticky err without touching the digit; clr clears all.
  task automatic test_illegal_clr();
    for (int i = 0; i < 8; i++) step(4'b0100, 7'b1010101, 1'b0);
    for (int i = 0; i < 4; i++) step(4'b0000, 7'b0000000, 1'b0);
    if (bus.err_out !== 1'b1) begin n_err++; $display("FAIL illegal_err got=%b exp=1", bus.err_out); end
    n_vec++;
    if (bus.digits_out !== 16'h4321) begin n_err++; $display("FAIL illegal_digits got=%h exp=4321", bus.digits_out); end
    n_vec++;
    if (bus.blank_out !== 4'h0) begin n_err++; $display("FAIL illegal_blank got=%h exp=0", bus.blank_out); end
    n_vec++;
    step(4'b0000, 7'b0000000, 1'b1);
    if (bus.err_out !== 1'b0) begin n_err++; $display("FAIL clr_err got=%b exp=0", bus.err_out); end
    n_vec++;
    if (bus.blank_out !== 4'hF) begin n_err++; $display("FAIL clr_blank got=%h exp=F", bus.blank_out); end
    n_vec++;
    if (bus.digits_out !== 16'h0000) begin n_err++; $display("FAIL clr_digits got=%h exp=0000", bus.digits_out); end
    n_vec++;
  endtask

  // Multi-hot strobe flags err; reset mid-dwell restarts the stability count.
  task automatic test_multihot_reset();
    logic [3:0] exp;
    for (int i = 0; i < 8; i++) step(4'b0011, 7'b0000110, 1'b0);
    if (bus.err_out !== 1'b1) begin n_err++; $display("FAIL multihot_err got=%b exp=1", bus.err_out); end
    n_vec++;
    if (bus.digits_out !== 16'h0000) begin n_err++; $display("FAIL multihot_digits got=%h exp=0000", bus.digits_out); end
    n_vec++;
    step(4'b0001, 7'b1001111, 1'b0);
    step(4'b0001, 7'b1001111, 1'b0);
    reset_n = 1'b0;
    #2;
    if (bus.err_out !== 1'b0) begin n_err++; $display("FAIL midrst_err got=%b exp=0", bus.err_out); end
    n_vec++;
    if (bus.blank_out !== 4'hF) begin n_err++; $display("FAIL midrst_blank got=%h exp=F", bus.blank_out); end
    n_vec++;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();
    for (int i = 0; i < int'(LAT) + 2; i++) begin
      step(4'b0001, 7'b1001111, 1'b0);
      exp = (i >= int'(LAT) - 1) ? 4'h3 : 4'h0;
      if (bus.digits_out[3:0] !== exp) begin n_err++; $display("FAIL midrst_dig0 i=%0d got=%h exp=%h", i, bus.digits_out[3:0], exp); end
      n_vec++;
    end
  endtask

  // Random dwells of random length against the reference model.
  task automatic test_random();
    logic [ND-1:0] an;
    logic [6:0]    sg;
    int            len;
    int            r;
    logic          c;
    int            cyc;
    cyc = 0;
    for (int d = 0; d < 300; d++) begin
      r = int'($urandom_range(0, 9));
      if (r <= 6)      an = 4'(1 << $urandom_range(0, ND - 1));
      else if (r == 7) an = '0;
      else             an = 4'($urandom);
      r = int'($urandom_range(0, 9));
      if (r <= 6)      sg = seg_tab[$urandom_range(0, 15)];
      else if (r == 7) sg = 7'd0;
      else             sg = 7'($urandom);
      len = int'($urandom_range(1, SC + 3));
      for (int i = 0; i < len; i++) begin
        c = ($urandom_range(0, 40) == 0);
        step(an, sg, c);
        cyc++;
        if (bus.digits_out !== m_dig) begin n_err++; $display("FAIL rnd_digits cyc=%0d got=%h exp=%h", cyc, bus.digits_out, m_dig); end
        n_vec++;
        if (bus.blank_out !== m_blank) begin n_err++; $display("FAIL rnd_blank cyc=%0d got=%h exp=%h", cyc, bus.blank_out, m_blank); end
        n_vec++;
        if (bus.err_out !== m_err) begin n_err++; $display("FAIL rnd_err cyc=%0d got=%b exp=%b", cyc, bus.err_out, m_err); end
        n_vec++;
        if (bus.frame_valid !== m_fv) begin n_err++; $display("FAIL rnd_fv cyc=%0d got=%b exp=%b", cyc, bus.frame_valid, m_fv); end
        n_vec++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_capture();
    test_frame();
    test_short_dwell();
    test_illegal_clr();
    test_multihot_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired got=timeout exp=finish");
    $fatal(1);
  end

endmodule
